// File: rtl/scan_seq_pkg.sv
// Shared types for the scan mode entry/exit sequencer.
// Holds the FSM state encoding and a small sizing helper.
package scan_seq_pkg;

  localparam int SEQ_STATE_W = 3;

  typedef enum logic [SEQ_STATE_W-1:0] {
    S_IDLE       = 3'd0,
    S_GATE_OFF   = 3'd1,
    S_SWITCH_IN  = 3'd2,
    S_SCAN       = 3'd3,
    S_SWITCH_OUT = 3'd4,
    S_GATE_ON    = 3'd5
  } seq_state_e;

  function automatic int max2(
    input int a,
    input int b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/scan_req_sync.sv
// Multi-flop synchronizer for the asynchronous scan request level.
// Ports: clk, rst_n (sync, active low), i_async -> o_sync.
module scan_req_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/scan_mode_seq_ctrl.sv
// Scan mode sequencer: gates the functional clock, staggers scan mux
// selects in LSB first, flags ready; exit runs in reverse.
// Ports: clk, rst_n, scan_req_in, scan_lock_in -> fcn_clk_en_out,
// scan_mode_en_out[NUM_MUX], scan_ready_out, seq_busy_out, seq_state_out.
module scan_mode_seq_ctrl
  import scan_seq_pkg::*;
#(
  parameter int NUM_MUX     = 4,
  parameter int GATE_CYC    = 4,
  parameter int STAGGER_CYC = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_req_in,
  input  logic                   scan_lock_in,
  output logic                   fcn_clk_en_out,
  output logic [NUM_MUX-1:0]     scan_mode_en_out,
  output logic                   scan_ready_out,
  output logic                   seq_busy_out,
  output logic [SEQ_STATE_W-1:0] seq_state_out
);

  localparam int CNT_W =
    $clog2(max2(GATE_CYC, STAGGER_CYC) + 1);
  localparam logic [CNT_W-1:0] GATE_LD =
    CNT_W'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LD =
    CNT_W'(STAGGER_CYC - 1);
  localparam logic [NUM_MUX-1:0] LANE0 =
    NUM_MUX'(1);

  logic               w_req_s;
  logic               w_go;
  logic               w_cnt_zero;
  seq_state_e         r_state;
  seq_state_e         w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [NUM_MUX-1:0] r_lanes;
  logic [NUM_MUX-1:0] w_lanes_nxt;
  logic               r_fcn_en;
  logic               w_fcn_en_nxt;
  logic               r_ready;
  logic               w_ready_nxt;
  logic               r_busy;
  logic               w_busy_nxt;

  scan_req_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (scan_req_in),
    .o_sync  (w_req_s)
  );

  assign w_go       = w_req_s & ~scan_lock_in;
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lanes  <= '0;
      r_fcn_en <= 1'b1;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lanes  <= w_lanes_nxt;
      r_fcn_en <= w_fcn_en_nxt;
      r_ready  <= w_ready_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  // One down-counter serves both gate and stagger waits; each
  // phase loads N-1 so the action lands exactly N edges later.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = w_cnt_zero ? r_cnt : r_cnt - CNT_W'(1);
    w_lanes_nxt  = r_lanes;
    w_fcn_en_nxt = r_fcn_en;
    w_ready_nxt  = r_ready;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt  = S_GATE_OFF;
          w_fcn_en_nxt = 1'b0;
          w_cnt_nxt    = GATE_LD;
        end
      end
      S_GATE_OFF: begin
        if (!w_go) begin
          w_state_nxt = S_GATE_ON;
          w_cnt_nxt   = GATE_LD;
        end else if (w_cnt_zero) begin
          w_state_nxt = S_SWITCH_IN;
          w_lanes_nxt = LANE0;
          w_cnt_nxt   = STAG_LD;
        end
      end
      S_SWITCH_IN: begin
        if (!w_go) begin
          w_state_nxt = S_SWITCH_OUT;
          w_cnt_nxt   = STAG_LD;
        end else if (w_cnt_zero) begin
          if (&r_lanes) begin
            w_state_nxt = S_SCAN;
            w_ready_nxt = 1'b1;
          end else begin
            w_lanes_nxt = (r_lanes << 1) | LANE0;
            w_cnt_nxt   = STAG_LD;
          end
        end
      end
      S_SCAN: begin
        if (!w_go) begin
          w_state_nxt = S_SWITCH_OUT;
          w_ready_nxt = 1'b0;
          w_cnt_nxt   = STAG_LD;
        end
      end
      S_SWITCH_OUT: begin
        if (w_cnt_zero) begin
          w_lanes_nxt = r_lanes >> 1;
          if ((r_lanes >> 1) == '0) begin
            w_state_nxt = S_GATE_ON;
            w_cnt_nxt   = GATE_LD;
          end else begin
            w_cnt_nxt   = STAG_LD;
          end
        end
      end
      S_GATE_ON: begin
        if (w_cnt_zero) begin
          w_state_nxt  = S_IDLE;
          w_fcn_en_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_lanes_nxt  = '0;
        w_fcn_en_nxt = 1'b1;
        w_ready_nxt  = 1'b0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE) &&
                 (w_state_nxt != S_SCAN);
  end

  assign fcn_clk_en_out   = r_fcn_en;
  assign scan_mode_en_out = r_lanes;
  assign scan_ready_out   = r_ready;
  assign seq_busy_out     = r_busy;
  assign seq_state_out    = r_state;

endmodule
